// File: rtl/m1_player_pkg.sv
// Shared types and constants for the m1 table player: FSM state encoding,
// default widths and the loop-counter saturation value.
package m1_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned C_ADDR_WIDTH = 6;
  localparam int unsigned C_DATA_WIDTH = 16;
  localparam int unsigned C_RD_LATENCY = 1;
  localparam int unsigned C_FIFO_DEPTH = 4;

  localparam logic [15:0] C_LOOP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/m1_player_fifo.sv
// Synchronous output FIFO for the table player; power-of-two depth, count output,
// simultaneous push and pop allowed.
module m1_player_fifo #(
  parameter int unsigned G_DEPTH = 4,
  parameter int unsigned G_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [G_WIDTH-1:0]         data_i,
  input  logic                       pop_i,
  output logic [G_WIDTH-1:0]         data_o,
  output logic [$clog2(G_DEPTH):0]   count_o,
  output logic                       empty_o
);

  localparam int unsigned LP_PW = $clog2(G_DEPTH);
  localparam logic [LP_PW:0] LP_FULL = (LP_PW + 1)'(G_DEPTH);

  logic [G_WIDTH-1:0] r_mem [G_DEPTH];
  logic [LP_PW-1:0]   r_wr_ptr;
  logic [LP_PW-1:0]   r_rd_ptr;
  logic [LP_PW:0]     r_count;
  logic               w_pop;

  assign w_pop = pop_i && (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push_i, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign empty_o = (r_count == '0);

  // Read credit upstream must make a push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_n)
    !(push_i && (r_count == LP_FULL)));

endmodule

// File: rtl/m1_table_player.sv
// Scans table RAM entries 0..len-1 and streams them as valid/ready samples,
// in one-shot or loop mode, with read credit sized to the output FIFO.
module m1_table_player
  import m1_player_pkg::*;
#(
  parameter int unsigned G_ADDR_WIDTH = C_ADDR_WIDTH,
  parameter int unsigned G_DATA_WIDTH = C_DATA_WIDTH,
  parameter int unsigned G_RD_LATENCY = C_RD_LATENCY,
  parameter int unsigned G_FIFO_DEPTH = C_FIFO_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    loop_i,
  input  logic [G_ADDR_WIDTH:0]   len_i,
  output logic [G_ADDR_WIDTH-1:0] mem_adr_o,
  output logic                    mem_rd_o,
  input  logic [G_DATA_WIDTH-1:0] mem_dat_i,
  output logic [G_DATA_WIDTH-1:0] smp_o,
  output logic                    smp_valid_o,
  input  logic                    smp_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             loop_cnt_o
);

  localparam int unsigned LP_LW = G_ADDR_WIDTH + 1;
  localparam int unsigned LP_CW = $clog2(G_FIFO_DEPTH) + 1;
  localparam logic [LP_LW-1:0] LP_FULL_LEN = LP_LW'(1) << G_ADDR_WIDTH;
  localparam logic [LP_CW:0]   LP_CREDIT   = (LP_CW + 1)'(G_FIFO_DEPTH);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [G_ADDR_WIDTH-1:0] r_adr;
  logic [LP_LW-1:0]        r_len;
  logic [15:0]             r_loop_cnt;
  logic [G_RD_LATENCY-1:0] r_dly;

  logic [LP_LW-1:0]        w_adr_inc;
  logic [LP_CW-1:0]        w_inflight;
  logic [LP_CW-1:0]        w_fifo_cnt;
  logic [G_DATA_WIDTH-1:0] w_fifo_dat;
  logic                    w_fifo_empty;
  logic                    w_credit;
  logic                    w_last;
  logic                    w_issue;
  logic                    w_done;

  assign w_adr_inc = {1'b0, r_adr} + LP_LW'(1);
  assign w_last    = (w_adr_inc == r_len);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < G_RD_LATENCY; i++) begin
      w_inflight = w_inflight + LP_CW'(r_dly[i]);
    end
  end

  // Registered counts only: a pop this cycle does not return credit until next cycle.
  assign w_credit = ({1'b0, w_inflight} + {1'b0, w_fifo_cnt}) < LP_CREDIT;

  always_ff @(posedge clk_i) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop_i) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if (w_last && !loop_i) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((w_inflight == '0) && w_fifo_empty) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_adr      <= '0;
      r_len      <= '0;
      r_loop_cnt <= '0;
      r_dly      <= '0;
    end else begin
      r_dly <= (r_dly << 1) | G_RD_LATENCY'(w_issue);
      if ((r_state == ST_IDLE) && start_i) begin
        r_len      <= (len_i == '0) ? LP_FULL_LEN : len_i;
        r_adr      <= '0;
        r_loop_cnt <= '0;
      end else if (w_issue) begin
        if (w_last && loop_i) begin
          r_adr <= '0;
          if (r_loop_cnt != C_LOOP_CNT_MAX) r_loop_cnt <= r_loop_cnt + 16'd1;
        end else begin
          r_adr <= w_adr_inc[G_ADDR_WIDTH-1:0];
        end
      end
    end
  end

  m1_player_fifo #(
    .G_DEPTH (G_FIFO_DEPTH),
    .G_WIDTH (G_DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (r_dly[G_RD_LATENCY-1]),
    .data_i  (mem_dat_i),
    .pop_i   (smp_ready_i),
    .data_o  (w_fifo_dat),
    .count_o (w_fifo_cnt),
    .empty_o (w_fifo_empty)
  );

  assign mem_adr_o   = r_adr;
  assign mem_rd_o    = w_issue;
  assign smp_valid_o = !w_fifo_empty;
  assign smp_o       = w_fifo_empty ? '0 : w_fifo_dat;
  assign busy_o      = (r_state == ST_RUN) || ((r_state == ST_DRAIN) && !w_done);
  assign done_o      = w_done;
  assign loop_cnt_o  = r_loop_cnt;

endmodule

// File: tb/tb_m1_table_player.sv
// Bench for m1_table_player: a registered-read table RAM model, a scoreboard that
// expects table[k mod len] for the k-th accepted sample, and directed plus random runs.
module tb_m1_table_player;

  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        loop_i = 1'b0;
  logic [6:0]  len_i = '0;
  logic [5:0]  mem_adr_o;
  logic        mem_rd_o;
  logic [15:0] mem_dat_i = '0;
  logic [15:0] smp_o;
  logic        smp_valid_o;
  logic        smp_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] loop_cnt_o;

  m1_table_player dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .loop_i      (loop_i),
    .len_i       (len_i),
    .mem_adr_o   (mem_adr_o),
    .mem_rd_o    (mem_rd_o),
    .mem_dat_i   (mem_dat_i),
    .smp_o       (smp_o),
    .smp_valid_o (smp_valid_o),
    .smp_ready_i (smp_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .loop_cnt_o  (loop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] tbl [64];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int k = 0, rd_cnt = 0, acc_cnt = 0, done_cnt = 0, max_occ = 0;
  int first_valid = -1, acc_first = 0, acc_last = 0, t_start = 0;
  int cur_len = 1;
  bit cur_loop = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Registered-read RAM port B model
  always @(posedge clk_i) if (mem_rd_o) mem_dat_i <= tbl[mem_adr_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  initial begin
    bit          prev_hold = 1'b0;
    logic [15:0] prev_smp = '0;
    int          occ;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) chk("hold", {15'd0, smp_valid_o, smp_o}, {15'd0, 1'b1, prev_smp});
        if (cur_loop) chk("loopcnt", loop_cnt_o, rd_cnt / cur_len);
        if (mem_rd_o) begin
          chk("adr", mem_adr_o, rd_cnt % cur_len);
          rd_cnt++;
        end
        occ = rd_cnt - acc_cnt;
        if (occ > max_occ) max_occ = occ;
        if (smp_valid_o && first_valid < 0) first_valid = cyc;
        if (smp_valid_o && smp_ready_i) begin
          chk("smp", smp_o, tbl[k % cur_len]);
          if (k == 0) acc_first = cyc;
          acc_last = cyc;
          k++;
          acc_cnt++;
        end
        if (done_o) begin
          done_cnt++;
          chk("busy_at_done", busy_o, 0);
        end
        prev_hold = smp_valid_o && !smp_ready_i;
        prev_smp  = smp_o;
      end
    end
  end

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rd"}, mem_rd_o, 0);
    chk({tag, "_adr"}, mem_adr_o, 0);
    chk({tag, "_smp"}, smp_o, 0);
    chk({tag, "_valid"}, smp_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_loopcnt"}, loop_cnt_o, 0);
  endtask

  task automatic start_run(input int len, input bit lp);
    @(posedge clk_i); #1;
    k = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0; max_occ = 0; first_valid = -1;
    cur_len  = (len == 0) ? 64 : len;
    cur_loop = lp;
    len_i    = 7'(len);
    loop_i   = lp;
    start_i  = 1'b1;
    @(negedge clk_i);
    t_start = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // mode 0: ready high, 1: ready toggles, 2: random ready
  task automatic drive_wait(input int mode, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
      else begin
        @(posedge clk_i); #1;
        case (mode)
          0:       smp_ready_i = 1'b1;
          1:       smp_ready_i = ~smp_ready_i;
          default: smp_ready_i = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
    if (!seen) chk("timeout", 0, 1);
    @(posedge clk_i); #1;
    smp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int len;
    for (int i = 0; i < 64; i++) tbl[i] = 16'h1000 + 16'(i);
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b1;
    @(negedge clk_i);
    chk_idle_outs("rst");

    // One-shot, len 4
    smp_ready_i = 1'b1;
    start_run(4, 1'b0);
    drive_wait(0, 100);
    chk("t1_latency", first_valid - t_start, 2 + LAT);
    chk("t1_count", k, 4);
    chk("t1_gapless", acc_last - acc_first, 3);
    chk("t1_done", done_cnt, 1);
    chk("t1_busy", busy_o, 0);

    // Full depth via len 0
    start_run(0, 1'b0);
    drive_wait(0, 200);
    chk("t2_count", k, 64);
    chk("t2_reads", rd_cnt, 64);
    chk("t2_gapless", acc_last - acc_first, 63);
    chk("t2_adr_wrap", mem_adr_o, 0);
    chk("t2_done", done_cnt, 1);

    // Loop mode, len 3, then stop
    start_run(3, 1'b1);
    for (int i = 0; i < 100 && k < 10; i++) @(negedge clk_i);
    @(posedge clk_i); #1 stop_i = 1'b1;
    @(posedge clk_i); #1 stop_i = 1'b0;
    drive_wait(0, 100);
    cur_loop = 1'b0;
    chk("t3_min_samples", k >= 10, 1);
    chk("t3_all_delivered", k, rd_cnt);
    chk("t3_loopcnt", loop_cnt_o, rd_cnt / 3);
    chk("t3_done", done_cnt, 1);

    // Ready toggling, len 8
    smp_ready_i = 1'b0;
    start_run(8, 1'b0);
    drive_wait(1, 200);
    chk("t4_count", k, 8);
    chk("t4_occ", max_occ <= DEPTH, 1);

    // Stop one cycle after the first read; start during DRAIN ignored
    start_run(16, 1'b0);
    for (int i = 0; i < 20 && rd_cnt == 0; i++) @(negedge clk_i);
    @(posedge clk_i); #1 stop_i = 1'b1;
    @(posedge clk_i); #1 stop_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    drive_wait(0, 50);
    repeat (3) @(negedge clk_i);
    chk("t5_reads", rd_cnt, 1);
    chk("t5_count", k, 1);
    chk("t5_done", done_cnt, 1);
    chk("t5_idle", busy_o, 0);

    // Reset mid-run with a full FIFO
    smp_ready_i = 1'b0;
    start_run(8, 1'b0);
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    chk("t6_pre_full", rd_cnt, DEPTH);
    @(posedge clk_i); #1 rst_n = 1'b0;
    @(posedge clk_i); #1 rst_n = 1'b1;
    @(negedge clk_i);
    chk_idle_outs("t6_post");
    chk("t6_no_done", done_cnt, 0);
    smp_ready_i = 1'b1;
    start_run(4, 1'b0);
    drive_wait(0, 100);
    chk("t6_replay", k, 4);

    // Random tables, lengths and backpressure
    for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 64);
      start_run(len, 1'b0);
      drive_wait(2, 3000);
      chk("rnd_count", k, cur_len);
      chk("rnd_reads", rd_cnt, cur_len);
      chk("rnd_done", done_cnt, 1);
      chk("rnd_occ", max_occ <= DEPTH, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
